// File: rtl/path_pkg.sv
// Shared types and constants for the maze path replay logic.
package path_pkg;

  localparam int COORD_W = 4;
  localparam int LOC_W   = 2 * COORD_W;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    FETCH,
    WAIT,
    EMIT,
    DONE,
    ERR
  } state_t;

  // A location is {x, y}; x lives in the upper half.
  function automatic logic [COORD_W-1:0] loc_x(input logic [LOC_W-1:0] loc);
    return loc[LOC_W-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] loc_y(input logic [LOC_W-1:0] loc);
    return loc[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/path_decoder_dir_encode.sv
// Turns a pair of grid cells into a move direction and an adjacency flag.
// Differences are taken one bit wider than a coordinate so the edge of the
// grid does not wrap: 15 -> 0 is a jump of -15, not a step of +1.
module dir_encode
  import path_pkg::*;
#(
  parameter int COORD_W = path_pkg::COORD_W
) (
  input  logic [2*COORD_W-1:0] prev_loc,
  input  logic [2*COORD_W-1:0] cur_loc,
  output logic [1:0]           dir,
  output logic                 adjacent
);

  localparam logic signed [COORD_W:0] D_ZERO = '0;
  localparam logic signed [COORD_W:0] D_POS  = {{COORD_W{1'b0}}, 1'b1};
  localparam logic signed [COORD_W:0] D_NEG  = '1;

  logic signed [COORD_W:0] dx;
  logic signed [COORD_W:0] dy;

  assign dx = $signed({1'b0, cur_loc[2*COORD_W-1:COORD_W]})
            - $signed({1'b0, prev_loc[2*COORD_W-1:COORD_W]});
  assign dy = $signed({1'b0, cur_loc[COORD_W-1:0]})
            - $signed({1'b0, prev_loc[COORD_W-1:0]});

  // Exactly one axis must move by exactly one cell.
  always_comb begin
    dir      = DIR_RIGHT;
    adjacent = 1'b0;
    if (dy == D_ZERO && dx == D_POS) begin
      dir      = DIR_RIGHT;
      adjacent = 1'b1;
    end else if (dy == D_ZERO && dx == D_NEG) begin
      dir      = DIR_LEFT;
      adjacent = 1'b1;
    end else if (dx == D_ZERO && dy == D_POS) begin
      dir      = DIR_DOWN;
      adjacent = 1'b1;
    end else if (dx == D_ZERO && dy == D_NEG) begin
      dir      = DIR_UP;
      adjacent = 1'b1;
    end
  end

endmodule

// File: rtl/path_decoder.sv
// Replays the stored maze path oldest-first and streams one direction per
// consecutive cell pair over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH0 | pop the start cell, or finish if the queue is empty
// WAIT0  | capture the start cell into prev_loc
// FETCH  | pop the next cell, or finish if the queue is empty
// WAIT   | capture the next cell, classify the move
// EMIT   | present dir/dir_loc until the consumer accepts
// DONE   | one-cycle fin pulse
// ERR    | non-adjacent cells or step overflow; waits for start
module path_decoder
  import path_pkg::*;
#(
  parameter int COORD_W   = path_pkg::COORD_W,
  parameter int MAX_STEPS = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 q_empty,
  input  logic [2*COORD_W-1:0] loc_in,
  output logic                 pop,
  output logic                 run,
  output logic                 dir_valid,
  input  logic                 dir_ready,
  output logic [1:0]           dir,
  output logic [2*COORD_W-1:0] dir_loc,
  output logic [7:0]           step_cnt,
  output logic                 busy,
  output logic                 fin,
  output logic                 err
);

  localparam int         LW      = 2 * COORD_W;
  localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

  state_t          state_q, state_d;
  logic [LW-1:0]   prev_loc_q, prev_loc_d;
  logic [LW-1:0]   cur_loc_q, cur_loc_d;
  logic [1:0]      dir_q, dir_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic            err_q, err_d;
  logic            dir_valid_q, dir_valid_d;
  logic            fin_q, fin_d;
  logic            busy_q, busy_d;
  logic            pop_c;

  logic [1:0]      enc_dir;
  logic            enc_adj;

  // The move being classified is always prev_loc -> the entry arriving now.
  dir_encode #(.COORD_W(COORD_W)) u_dir_encode (
    .prev_loc (prev_loc_q),
    .cur_loc  (loc_in),
    .dir      (enc_dir),
    .adjacent (enc_adj)
  );

  // Next-state and next-output computation for the replay sequencer.
  always_comb begin
    state_d     = state_q;
    prev_loc_d  = prev_loc_q;
    cur_loc_d   = cur_loc_q;
    dir_d       = dir_q;
    step_cnt_d  = step_cnt_q;
    err_d       = err_q;
    pop_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          step_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = FETCH0;
        end
      end
      FETCH0: begin
        if (q_empty) begin
          state_d = DONE;
        end else begin
          pop_c   = 1'b1;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        prev_loc_d = loc_in;
        state_d    = FETCH;
      end
      FETCH: begin
        if (q_empty) begin
          state_d = DONE;
        end else begin
          pop_c   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cur_loc_d = loc_in;
        // Overflow is only checked for moves that would otherwise be emitted.
        if (!enc_adj || step_cnt_q == MAX_CNT) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          dir_d   = enc_dir;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (dir_ready) begin
          step_cnt_d = step_cnt_q + 8'd1;
          prev_loc_d = cur_loc_q;
          state_d    = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        if (start) begin
          step_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = FETCH0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    dir_valid_d = (state_d == EMIT);
    fin_d       = (state_d == DONE);
    busy_d      = !(state_d == IDLE || state_d == DONE || state_d == ERR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      prev_loc_q  <= '0;
      cur_loc_q   <= '0;
      dir_q       <= '0;
      step_cnt_q  <= '0;
      err_q       <= 1'b0;
      dir_valid_q <= 1'b0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_loc_q  <= prev_loc_d;
      cur_loc_q   <= cur_loc_d;
      dir_q       <= dir_d;
      step_cnt_q  <= step_cnt_d;
      err_q       <= err_d;
      dir_valid_q <= dir_valid_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
    end
  end

  // pop follows the queue's one-cycle read latency: issued in FETCH/FETCH0,
  // data consumed in the following WAIT/WAIT0.
  assign pop       = pop_c;
  assign run       = busy_q;
  assign busy      = busy_q;
  assign dir_valid = dir_valid_q;
  assign dir       = dir_q;
  assign dir_loc   = cur_loc_q;
  assign step_cnt  = step_cnt_q;
  assign fin       = fin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_path_decoder.sv
// Scoreboard bench for path_decoder: a queue model feeds cells, a grid-move
// reference model predicts directions, and a monitor checks the stream.
module tb_path_decoder;
  import path_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       q_empty;
  logic [7:0] loc_in = 8'h00;
  logic       pop, run, dir_valid, busy, fin, err;
  logic       dir_ready = 1'b1;
  logic [1:0] dir;
  logic [7:0] dir_loc, step_cnt;

  always #5 clk = ~clk;

  path_decoder dut (
    .clk(clk), .rst(rst), .start(start), .q_empty(q_empty), .loc_in(loc_in),
    .pop(pop), .run(run), .dir_valid(dir_valid), .dir_ready(dir_ready),
    .dir(dir), .dir_loc(dir_loc), .step_cnt(step_cnt), .busy(busy),
    .fin(fin), .err(err)
  );

  // Path queue model: one-cycle read latency.
  logic [7:0] mem [0:299];
  int         q_len = 0;
  int         rd_idx = 0;
  logic       q_clr = 1'b0;
  assign q_empty = (rd_idx >= q_len);

  always @(posedge clk) begin
    if (q_clr) rd_idx <= 0;
    else if (pop && rd_idx < q_len) begin
      loc_in <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [1:0] d;
    logic [7:0] l;
  } exp_t;
  exp_t exp_q[$];

  // Monitor
  int         acc_cnt = 0;
  int         pop_cnt = 0;
  int         fin_cnt = 0;
  bit         mon_en = 1'b0;
  bit         prev_pop = 1'b0;
  bit         held = 1'b0;
  logic [1:0] h_dir;
  logic [7:0] h_loc;

  always @(negedge clk) begin
    if (mon_en) begin
      check("step_cnt_track", int'(step_cnt), acc_cnt);
      if (prev_pop) check("pop_back_to_back", int'(pop), 0);
      if (dir_valid) check("pop_during_emit", int'(pop), 0);
      if (held) begin
        check("hold_valid", int'(dir_valid), 1);
        check("hold_dir", int'(dir), int'(h_dir));
        check("hold_loc", int'(dir_loc), int'(h_loc));
      end
      held = 1'b0;
      if (!rst) begin
        acc_cnt = 0; pop_cnt = 0; fin_cnt = 0; prev_pop = 1'b0;
      end else begin
        if (start) begin
          acc_cnt = 0; pop_cnt = 0; fin_cnt = 0;
        end
        if (pop) pop_cnt++;
        prev_pop = pop;
        if (fin) fin_cnt++;
        if (dir_valid && dir_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_dir: got dir=%0d loc=%02h, required none", dir, dir_loc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("dir", int'(dir), int'(e.d));
            check("dir_loc", int'(dir_loc), int'(e.l));
          end
          acc_cnt++;
        end else if (dir_valid) begin
          held = 1'b1;
          h_dir = dir;
          h_loc = dir_loc;
        end
      end
    end
  end

  // Consumer: 0 always ready, 1 random, 2 stall 4 cycles on the 2nd move, 3 never.
  int rdy_mode = 0;
  initial begin
    int stall_used;
    stall_used = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) stall_used = 0;
      case (rdy_mode)
        0: dir_ready = 1'b1;
        1: dir_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (dir_valid && acc_cnt == 1 && stall_used < 4) begin
            dir_ready = 1'b0;
            stall_used++;
          end else dir_ready = 1'b1;
        end
        default: dir_ready = 1'b0;
      endcase
    end
  end

  task automatic load(input int n, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] a3);
    mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
    q_len = n;
  endtask

  task automatic build_rand(input int n, input bit corrupt);
    int x, y, d;
    x = $urandom_range(0, 15);
    y = $urandom_range(0, 15);
    mem[0] = {4'(x), 4'(y)};
    for (int i = 1; i < n; i++) begin
      d = $urandom_range(0, 3);
      if (d == 0 && x == 15) d = 1;
      else if (d == 1 && x == 0) d = 0;
      else if (d == 2 && y == 15) d = 3;
      else if (d == 3 && y == 0) d = 2;
      case (d)
        0: x++;
        1: x--;
        2: y++;
        default: y--;
      endcase
      mem[i] = {4'(x), 4'(y)};
      if (corrupt && i == n / 2) begin
        mem[i] = 8'($urandom_range(0, 255));
        x = int'(mem[i][7:4]);
        y = int'(mem[i][3:0]);
      end
    end
    q_len = n;
  endtask

  // Loads the queue, predicts the outcome from grid arithmetic, replays.
  task automatic run_scn(input int mode, input int exp_cycles);
    int steps, pops, cyc, dx, dy, dd;
    bit eerr, seen;
    exp_t e;
    steps = 0; pops = 0; cyc = 0; eerr = 1'b0; seen = 1'b0;
    @(posedge clk); #1 q_clr = 1'b1;
    @(posedge clk); #1 q_clr = 1'b0;
    exp_q.delete();
    pops = q_len;
    for (int i = 1; i < q_len; i++) begin
      dx = int'(loc_x(mem[i])) - int'(loc_x(mem[i-1]));
      dy = int'(loc_y(mem[i])) - int'(loc_y(mem[i-1]));
      if (dx * dx + dy * dy != 1 || steps == 255) begin
        eerr = 1'b1;
        pops = i + 1;
        break;
      end
      if (dx == 1) dd = 0;
      else if (dx == -1) dd = 1;
      else if (dy == 1) dd = 2;
      else dd = 3;
      e.d = 2'(dd);
      e.l = mem[i];
      exp_q.push_back(e);
      steps++;
    end
    rdy_mode = mode;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (fin || err) begin
        seen = 1'b1;
        break;
      end
    end
    check("finish_seen", int'(seen), 1);
    check("err", int'(err), int'(eerr));
    check("final_step_cnt", int'(step_cnt), steps);
    check("pop_count", pop_cnt, pops);
    check("leftover_expected", exp_q.size(), 0);
    if (exp_cycles > 0) check("fin_latency", cyc, exp_cycles);
    @(negedge clk);
    check("fin_one_cycle", int'(fin), 0);
    check("busy_end", int'(busy), 0);
    check("valid_end", int'(dir_valid), 0);
    check("err_sticky", int'(err), int'(eerr));
    check("fin_pulses", fin_cnt, eerr ? 0 : 1);
  endtask

  initial begin
    int cyc;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_pop", int'(pop), 0);
    check("rst_valid", int'(dir_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_run", int'(run), 0);
    check("rst_fin", int'(fin), 0);
    check("rst_err", int'(err), 0);
    check("rst_step_cnt", int'(step_cnt), 0);
    mon_en = 1'b1;

    load(4, 8'h00, 8'h10, 8'h11, 8'h21);  run_scn(0, -1);
    load(4, 8'h00, 8'h10, 8'h11, 8'h21);  run_scn(2, -1);
    load(2, 8'h22, 8'h24, 8'h00, 8'h00);  run_scn(0, -1);
    load(4, 8'h00, 8'h10, 8'h11, 8'h21);  run_scn(1, -1);
    load(2, 8'hF0, 8'h00, 8'h00, 8'h00);  run_scn(0, -1);
    load(2, 8'h0F, 8'h00, 8'h00, 8'h00);  run_scn(0, -1);
    load(2, 8'h55, 8'h55, 8'h00, 8'h00);  run_scn(0, -1);
    load(0, 8'h00, 8'h00, 8'h00, 8'h00);  run_scn(0, 2);
    load(1, 8'h33, 8'h00, 8'h00, 8'h00);  run_scn(0, 4);

    // Reset while a direction is pending.
    load(3, 8'h00, 8'h10, 8'h11, 8'h00);
    @(posedge clk); #1 q_clr = 1'b1;
    @(posedge clk); #1 q_clr = 1'b0;
    exp_q.delete();
    rdy_mode = 3;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (dir_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("emit_reached", int'(seen), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_emit_valid", int'(dir_valid), 0);
    check("rst_emit_step", int'(step_cnt), 0);
    check("rst_emit_busy", int'(busy), 0);
    check("rst_emit_err", int'(err), 0);
    check("rst_emit_fin", int'(fin), 0);
    load(4, 8'h00, 8'h10, 8'h11, 8'h21);  run_scn(0, -1);

    // Step counter boundary: 255 moves finish, the 256th overflows.
    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 1) ? 8'h10 : 8'h00;
    q_len = 256;
    run_scn(0, -1);
    for (int i = 0; i < 257; i++) mem[i] = (i % 2 == 1) ? 8'h10 : 8'h00;
    q_len = 257;
    run_scn(1, -1);

    for (int k = 0; k < 20; k++) begin
      build_rand($urandom_range(0, 12), ($urandom_range(0, 3) == 0));
      run_scn(1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
